// File: rtl/accel_spi_sequencer.sv
// rtl/accel_spi_sequencer.sv - ADXL345 configuration and axis polling sequencer in front of the SPI serializer
//
// Ports:
//   spi_clk          clock shared with the serializer
//   reset            asynchronous, active-low reset
//   o_start          one-cycle transaction request to the serializer
//   o_data_tx[15:0]  transaction word, held from o_start until i_done
//   i_done           serializer completion pulse
//   i_data_rx[7:0]   serializer read byte, valid with i_done
//   o_accel_x/y/z    signed 16-bit axis samples {DATAn1, DATAn0}
//   o_sample_valid   one-cycle strobe when all three axes update
//   o_init_done      configuration writes completed
//   o_error          sticky transaction-timeout flag
module accel_spi_sequencer #(
  parameter int POWERUP_CYCLES = 16,
  parameter int POLL_DIV       = 1024,
  parameter int TIMEOUT        = 64
) (
  input  logic        spi_clk,
  input  logic        reset,
  output logic        o_start,
  output logic [15:0] o_data_tx,
  input  logic        i_done,
  input  logic [7:0]  i_data_rx,
  output logic [15:0] o_accel_x,
  output logic [15:0] o_accel_y,
  output logic [15:0] o_accel_z,
  output logic        o_sample_valid,
  output logic        o_init_done,
  output logic        o_error
);

  typedef enum logic [2:0] {
    S_PWRUP,
    S_INIT_ISSUE,
    S_INIT_WAIT,
    S_POLL_WAIT,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_PUBLISH
  } state_t;

  localparam logic [31:0] PU_LAST   = 32'(POWERUP_CYCLES - 1);
  localparam logic [31:0] POLL_LAST = 32'(POLL_DIV - 1);
  localparam logic [31:0] TO_LAST   = 32'(TIMEOUT - 1);

  state_t      r_state;
  logic [31:0] r_cnt;
  logic [2:0]  r_idx;
  logic        r_start;
  logic [15:0] r_data_tx;
  logic        r_init_done;
  logic        r_error;
  logic        r_sample_valid;
  logic [15:0] r_accel_x;
  logic [15:0] r_accel_y;
  logic [15:0] r_accel_z;
  logic [7:0]  r_buf [0:5];

  state_t      w_state_nxt;
  logic [31:0] w_cnt_nxt;
  logic [2:0]  w_idx_nxt;
  logic        w_start_nxt;
  logic [15:0] w_data_tx_nxt;
  logic        w_init_done_nxt;
  logic        w_error_nxt;
  logic        w_valid_nxt;
  logic        w_buf_we;
  logic        w_publish;

  // Write word: {rd=0, mb=0, addr[5:0], data[7:0]}
  function automatic logic [15:0] init_word(input logic [2:0] idx);
    logic [5:0] addr;
    logic [7:0] data;
    case (idx)
      3'd0:    begin addr = 6'h31; data = 8'h08; end
      3'd1:    begin addr = 6'h2C; data = 8'h0A; end
      default: begin addr = 6'h2D; data = 8'h08; end
    endcase
    return {1'b0, 1'b0, addr, data};
  endfunction

  // Read word: {rd=1, mb=0, addr[5:0], 8'h00}; DATAX0..DATAZ1 at 0x32..0x37
  function automatic logic [15:0] read_word(input logic [2:0] idx);
    logic [5:0] addr;
    addr = 6'h32 + {3'b000, idx};
    return {1'b1, 1'b0, addr, 8'h00};
  endfunction

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_idx_nxt       = r_idx;
    w_start_nxt     = 1'b0;
    w_data_tx_nxt   = r_data_tx;
    w_init_done_nxt = r_init_done;
    w_error_nxt     = r_error;
    w_valid_nxt     = 1'b0;
    w_buf_we        = 1'b0;
    w_publish       = 1'b0;

    case (r_state)
      S_PWRUP: begin
        if (r_cnt == PU_LAST) begin
          w_state_nxt   = S_INIT_ISSUE;
          w_cnt_nxt     = 32'd0;
          w_idx_nxt     = 3'd0;
          w_start_nxt   = 1'b1;
          w_data_tx_nxt = init_word(3'd0);
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end

      S_INIT_ISSUE: begin
        w_state_nxt = S_INIT_WAIT;
        w_cnt_nxt   = 32'd0;
      end

      S_INIT_WAIT: begin
        if (i_done) begin
          w_cnt_nxt = 32'd0;
          if (r_idx == 3'd2) begin
            w_init_done_nxt = 1'b1;
            w_state_nxt     = S_POLL_WAIT;
          end else begin
            w_idx_nxt     = r_idx + 3'd1;
            w_state_nxt   = S_INIT_ISSUE;
            w_start_nxt   = 1'b1;
            w_data_tx_nxt = init_word(r_idx + 3'd1);
          end
        end else if (r_cnt == TO_LAST) begin
          w_error_nxt     = 1'b1;
          w_init_done_nxt = 1'b0;
          w_state_nxt     = S_INIT_ISSUE;
          w_idx_nxt       = 3'd0;
          w_cnt_nxt       = 32'd0;
          w_start_nxt     = 1'b1;
          w_data_tx_nxt   = init_word(3'd0);
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end

      S_POLL_WAIT: begin
        if (r_cnt == POLL_LAST) begin
          w_state_nxt   = S_RD_ISSUE;
          w_cnt_nxt     = 32'd0;
          w_idx_nxt     = 3'd0;
          w_start_nxt   = 1'b1;
          w_data_tx_nxt = read_word(3'd0);
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end

      S_RD_ISSUE: begin
        w_state_nxt = S_RD_WAIT;
        w_cnt_nxt   = 32'd0;
      end

      S_RD_WAIT: begin
        if (i_done) begin
          w_buf_we  = 1'b1;
          w_cnt_nxt = 32'd0;
          if (r_idx == 3'd5) begin
            // Outputs load on this edge so they change in the PUBLISH cycle itself
            w_publish   = 1'b1;
            w_valid_nxt = 1'b1;
            w_state_nxt = S_PUBLISH;
          end else begin
            w_idx_nxt     = r_idx + 3'd1;
            w_state_nxt   = S_RD_ISSUE;
            w_start_nxt   = 1'b1;
            w_data_tx_nxt = read_word(r_idx + 3'd1);
          end
        end else if (r_cnt == TO_LAST) begin
          // Partial buffer is abandoned; it is simply overwritten next round
          w_error_nxt     = 1'b1;
          w_init_done_nxt = 1'b0;
          w_state_nxt     = S_INIT_ISSUE;
          w_idx_nxt       = 3'd0;
          w_cnt_nxt       = 32'd0;
          w_start_nxt     = 1'b1;
          w_data_tx_nxt   = init_word(3'd0);
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end

      S_PUBLISH: begin
        w_state_nxt = S_POLL_WAIT;
        w_cnt_nxt   = 32'd0;
      end

      default: begin
        w_state_nxt = S_PWRUP;
        w_cnt_nxt   = 32'd0;
      end
    endcase
  end

  always_ff @(posedge spi_clk or negedge reset) begin
    if (!reset) begin
      r_state        <= S_PWRUP;
      r_cnt          <= 32'd0;
      r_idx          <= 3'd0;
      r_start        <= 1'b0;
      r_data_tx      <= 16'hFFFF;
      r_init_done    <= 1'b0;
      r_error        <= 1'b0;
      r_sample_valid <= 1'b0;
      r_accel_x      <= 16'h0000;
      r_accel_y      <= 16'h0000;
      r_accel_z      <= 16'h0000;
      for (int i = 0; i < 6; i++) begin
        r_buf[i] <= 8'h00;
      end
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_idx          <= w_idx_nxt;
      r_start        <= w_start_nxt;
      r_data_tx      <= w_data_tx_nxt;
      r_init_done    <= w_init_done_nxt;
      r_error        <= w_error_nxt;
      r_sample_valid <= w_valid_nxt;
      for (int i = 0; i < 6; i++) begin
        if (w_buf_we && (r_idx == 3'(i))) begin
          r_buf[i] <= i_data_rx;
        end
      end
      if (w_publish) begin
        r_accel_x <= {r_buf[1], r_buf[0]};
        r_accel_y <= {r_buf[3], r_buf[2]};
        r_accel_z <= {i_data_rx, r_buf[4]};
      end
    end
  end

  assign o_start        = r_start;
  assign o_data_tx      = r_data_tx;
  assign o_init_done    = r_init_done;
  assign o_error        = r_error;
  assign o_sample_valid = r_sample_valid;
  assign o_accel_x      = r_accel_x;
  assign o_accel_y      = r_accel_y;
  assign o_accel_z      = r_accel_z;

endmodule

// File: tb/tb_accel_spi_sequencer.sv
// tb/tb_accel_spi_sequencer.sv - directed bench for accel_spi_sequencer with a serializer model
module tb_accel_spi_sequencer;
  localparam int PU = 16;
  localparam int PD = 32;
  localparam int TO = 64;

  logic        spi_clk = 1'b0;
  logic        reset   = 1'b0;
  logic        o_start;
  logic [15:0] o_data_tx;
  logic        i_done    = 1'b0;
  logic [7:0]  i_data_rx = 8'h00;
  logic [15:0] o_accel_x, o_accel_y, o_accel_z;
  logic        o_sample_valid, o_init_done, o_error;

  accel_spi_sequencer #(.POWERUP_CYCLES(PU), .POLL_DIV(PD), .TIMEOUT(TO)) dut (
    .spi_clk(spi_clk), .reset(reset), .o_start(o_start), .o_data_tx(o_data_tx),
    .i_done(i_done), .i_data_rx(i_data_rx), .o_accel_x(o_accel_x), .o_accel_y(o_accel_y),
    .o_accel_z(o_accel_z), .o_sample_valid(o_sample_valid), .o_init_done(o_init_done),
    .o_error(o_error)
  );

  always #5 spi_clk = ~spi_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge spi_clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Serializer model: done 17 cycles after each start, read data from rd_bytes by address
  logic [7:0]  rd_bytes [6];
  logic        suppress_en   = 1'b0;
  logic [5:0]  suppress_addr = 6'h00;
  logic        inj           = 1'b0;
  logic        busy          = 1'b0;
  int          t_start       = 0;
  logic [15:0] t_word        = 16'h0;
  logic [15:0] start_word [$];
  int          start_cyc  [$];
  int          valid_total = 0;

  initial begin
    forever begin
      @(negedge spi_clk);
      if (!reset) begin
        busy   = 1'b0;
        i_done = 1'b0;
      end else begin
        i_done = 1'b0;
        if (busy && cyc == t_start + 17) begin
          busy = 1'b0;
          if (suppress_en && t_word[13:8] == suppress_addr) begin
            suppress_en = 1'b0;
          end else begin
            int k;
            i_done = 1'b1;
            k = int'(t_word[13:8]) - 'h32;
            if (t_word[15] && k >= 0 && k < 6) i_data_rx = rd_bytes[k];
          end
        end
        if (inj) begin
          i_done = 1'b1;
          inj    = 1'b0;
        end
        if (o_start) begin
          busy    = 1'b1;
          t_start = cyc;
          t_word  = o_data_tx;
          start_word.push_back(o_data_tx);
          start_cyc.push_back(cyc);
        end
        if (o_sample_valid) valid_total++;
      end
    end
  end

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge spi_clk);
    checks++; if (o_start !== 1'b0) begin errors++; $display("FAIL rst_start got %b want 0", o_start); end
    checks++; if (o_data_tx !== 16'hFFFF) begin errors++; $display("FAIL rst_data_tx got %h want ffff", o_data_tx); end
    checks++; if ({o_accel_x, o_accel_y, o_accel_z} !== 48'h0) begin errors++; $display("FAIL rst_accel got %h want 0", {o_accel_x, o_accel_y, o_accel_z}); end
    checks++; if ({o_sample_valid, o_init_done, o_error} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b want 000", {o_sample_valid, o_init_done, o_error}); end
  endtask

  task automatic test_init();
    int rise = -1;
    logic [15:0] exp_w [3];
    int exp_c [3];
    exp_w[0] = 16'h3108; exp_w[1] = 16'h2C0A; exp_w[2] = 16'h2D08;
    exp_c[0] = 16;       exp_c[1] = 34;       exp_c[2] = 52;
    start_word.delete(); start_cyc.delete();
    reset = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge spi_clk);
      if (cyc == 40) begin
        checks++; if (o_data_tx !== 16'h2C0A) begin errors++; $display("FAIL init_tx_hold got %h want 2c0a", o_data_tx); end
      end
      if (o_init_done) begin rise = cyc; break; end
    end
    checks++; if (rise != PU + 54) begin errors++; $display("FAIL init_done_cycle got %0d want %0d", rise, PU + 54); end
    @(negedge spi_clk);
    checks++;
    if (start_word.size() != 3) begin
      errors++; $display("FAIL init_start_count got %0d want 3", start_word.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++; if (start_word[k] !== exp_w[k]) begin errors++; $display("FAIL init_word%0d got %h want %h", k, start_word[k], exp_w[k]); end
        checks++; if (start_cyc[k] != exp_c[k]) begin errors++; $display("FAIL init_cycle%0d got %0d want %0d", k, start_cyc[k], exp_c[k]); end
      end
    end
  endtask

  task automatic test_read();
    int base = start_word.size();
    int vc = -1;
    int first = PU + 54 + PD;
    for (int i = 0; i < PD + 300; i++) begin
      @(negedge spi_clk);
      if (o_sample_valid) begin vc = cyc; break; end
    end
    checks++; if (vc != first + 108) begin errors++; $display("FAIL read_valid_cycle got %0d want %0d", vc, first + 108); end
    checks++; if (o_accel_x !== 16'h1234) begin errors++; $display("FAIL read_accel_x got %h want 1234", o_accel_x); end
    checks++; if (o_accel_y !== 16'hABCD) begin errors++; $display("FAIL read_accel_y got %h want abcd", o_accel_y); end
    checks++; if (o_accel_z !== 16'h8000) begin errors++; $display("FAIL read_accel_z got %h want 8000", o_accel_z); end
    checks++;
    if (start_word.size() < base + 6) begin
      errors++; $display("FAIL read_start_count got %0d want %0d", start_word.size() - base, 6);
    end else begin
      for (int k = 0; k < 6; k++) begin
        logic [15:0] ew;
        ew = 16'hB200 + 16'(k * 256);
        checks++; if (start_word[base + k] !== ew) begin errors++; $display("FAIL read_word%0d got %h want %h", k, start_word[base + k], ew); end
        checks++; if (start_cyc[base + k] != first + 18 * k) begin errors++; $display("FAIL read_cycle%0d got %0d want %0d", k, start_cyc[base + k], first + 18 * k); end
      end
    end
    @(negedge spi_clk);
    checks++; if (o_sample_valid !== 1'b0) begin errors++; $display("FAIL read_valid_width got %b want 0", o_sample_valid); end
    checks++; if (o_accel_x !== 16'h1234) begin errors++; $display("FAIL read_accel_hold got %h want 1234", o_accel_x); end
  endtask

  task automatic test_timeout();
    int base = start_word.size();
    int vbase = valid_total;
    int ec = -1;
    int j = -1;
    suppress_addr = 6'h35;
    suppress_en   = 1'b1;
    for (int i = 0; i < PD + 400; i++) begin
      @(negedge spi_clk);
      if (o_error) begin ec = cyc; break; end
    end
    @(negedge spi_clk);
    for (int k = base; k < start_word.size(); k++) begin
      if (start_word[k] == 16'hB500) begin j = k; break; end
    end
    checks++;
    if (j < 0 || j + 1 >= start_word.size()) begin
      errors++; $display("FAIL to_find_start got index %0d want valid", j);
    end else begin
      checks++; if (ec != start_cyc[j] + TO + 1) begin errors++; $display("FAIL to_error_cycle got %0d want %0d", ec, start_cyc[j] + TO + 1); end
      checks++; if (start_word[j + 1] !== 16'h3108) begin errors++; $display("FAIL to_restart_word got %h want 3108", start_word[j + 1]); end
      checks++; if (start_cyc[j + 1] != start_cyc[j] + TO + 1) begin errors++; $display("FAIL to_restart_cycle got %0d want %0d", start_cyc[j + 1], start_cyc[j] + TO + 1); end
    end
    checks++; if (o_init_done !== 1'b0) begin errors++; $display("FAIL to_init_done got %b want 0", o_init_done); end
    checks++; if ({o_accel_x, o_accel_y, o_accel_z} !== 48'h1234_ABCD_8000) begin errors++; $display("FAIL to_accel got %h want 1234abcd8000", {o_accel_x, o_accel_y, o_accel_z}); end
    checks++; if (valid_total != vbase) begin errors++; $display("FAIL to_no_valid got %0d want %0d", valid_total, vbase); end
    for (int i = 0; i < 200; i++) begin
      @(negedge spi_clk);
      if (o_init_done) break;
    end
    checks++; if ({o_init_done, o_error} !== 2'b11) begin errors++; $display("FAIL to_reinit got %b want 11", {o_init_done, o_error}); end
  endtask

  task automatic test_reset_mid();
    logic seen = 1'b0;
    for (int i = 0; i < PD + 300; i++) begin
      @(negedge spi_clk);
      if (o_start && o_data_tx == 16'hB300) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL rmid_find got %b want 1", seen); end
    repeat (5) @(negedge spi_clk);
    reset = 1'b0;
    #1;
    checks++; if ({o_start, o_sample_valid, o_init_done, o_error} !== 4'b0000) begin errors++; $display("FAIL rmid_flags got %b want 0000", {o_start, o_sample_valid, o_init_done, o_error}); end
    checks++; if (o_data_tx !== 16'hFFFF) begin errors++; $display("FAIL rmid_data_tx got %h want ffff", o_data_tx); end
    checks++; if ({o_accel_x, o_accel_y, o_accel_z} !== 48'h0) begin errors++; $display("FAIL rmid_accel got %h want 0", {o_accel_x, o_accel_y, o_accel_z}); end
    repeat (3) @(negedge spi_clk);
    start_word.delete(); start_cyc.delete();
    rd_bytes[0] = 8'h01; rd_bytes[1] = 8'h02; rd_bytes[2] = 8'h03;
    rd_bytes[3] = 8'h04; rd_bytes[4] = 8'h05; rd_bytes[5] = 8'h06;
    reset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge spi_clk);
      if (start_word.size() > 0) break;
    end
    checks++;
    if (start_word.size() == 0) begin
      errors++; $display("FAIL rmid_restart got none want start");
    end else begin
      checks++; if (start_cyc[0] != PU) begin errors++; $display("FAIL rmid_restart_cycle got %0d want %0d", start_cyc[0], PU); end
      checks++; if (start_word[0] !== 16'h3108) begin errors++; $display("FAIL rmid_restart_word got %h want 3108", start_word[0]); end
    end
    checks++; if (o_error !== 1'b0) begin errors++; $display("FAIL rmid_error got %b want 0", o_error); end
  endtask

  task automatic test_back_to_back();
    int prev = 0;
    int prev_n = 0;
    for (int r = 0; r < 21; r++) begin
      int vc = -1;
      for (int i = 0; i < PD + 300; i++) begin
        @(negedge spi_clk);
        if (o_sample_valid) begin vc = cyc; break; end
      end
      checks++;
      if (vc < 0) begin
        errors++; $display("FAIL b2b_valid round %0d got none want pulse", r);
        break;
      end
      if (r > 0) begin
        checks++; if (vc - prev != PD + 109) begin errors++; $display("FAIL b2b_period round %0d got %0d want %0d", r, vc - prev, PD + 109); end
        checks++; if (start_word.size() - prev_n != 6) begin errors++; $display("FAIL b2b_starts round %0d got %0d want 6", r, start_word.size() - prev_n); end
      end
      prev   = vc;
      prev_n = start_word.size();
      checks++; if ({o_accel_x, o_accel_y, o_accel_z} !== 48'h0201_0403_0605) begin errors++; $display("FAIL b2b_accel round %0d got %h want 020104030605", r, {o_accel_x, o_accel_y, o_accel_z}); end
      @(negedge spi_clk);
      checks++; if (o_sample_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_width round %0d got %b want 0", r, o_sample_valid); end
      repeat (4) @(negedge spi_clk);
      inj = 1'b1;
    end
    checks++; if (o_error !== 1'b0) begin errors++; $display("FAIL b2b_error got %b want 0", o_error); end
  endtask

  initial begin
    rd_bytes[0] = 8'h34; rd_bytes[1] = 8'h12; rd_bytes[2] = 8'hCD;
    rd_bytes[3] = 8'hAB; rd_bytes[4] = 8'h00; rd_bytes[5] = 8'h80;
    test_reset();
    test_init();
    test_read();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
